// File: rtl/gat_pkg.sv
// Shared definitions for the GAT attention datapath: FSM state encoding and
// width helpers for the coefficient gather stage.
package gat_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_NUM = 2'd1,
    GATHER  = 2'd2,
    OUT     = 2'd3
  } coef_gather_state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_NODES  = 168;

  function automatic int num_node_w(input int max_nodes);
    return (max_nodes > 1) ? $clog2(max_nodes) : 1;
  endfunction

  function automatic int coef_row_w(input int data_width, input int max_nodes);
    return data_width * max_nodes;
  endfunction

  localparam int DEF_NUM_NODE_WIDTH = num_node_w(DEF_MAX_NODES);
  localparam int COEF_ROW_W         = coef_row_w(DEF_DATA_WIDTH, DEF_MAX_NODES);

endpackage

// File: rtl/coef_gather_if.sv
// Row handshake between coef_gather (master) and the softmax input register (slave).
import gat_pkg::*;

interface coef_gather_if #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_NODES      = DEF_MAX_NODES,
  parameter int NUM_NODE_WIDTH = num_node_w(MAX_NODES)
);
  logic                            sm_vld_o;
  logic                            sm_rdy_i;
  logic [MAX_NODES*DATA_WIDTH-1:0] sm_coef_o;
  logic [NUM_NODE_WIDTH-1:0]       sm_num_node_o;
  logic [DATA_WIDTH-1:0]           sm_max_o;

  modport master (
    output sm_vld_o, sm_coef_o, sm_num_node_o, sm_max_o,
    input  sm_rdy_i
  );

  modport slave (
    input  sm_vld_o, sm_coef_o, sm_num_node_o, sm_max_o,
    output sm_rdy_i
  );
endinterface

// File: rtl/coef_row_buf.sv
// Slot-addressed coefficient row register with clear. Running row maximum is
// tracked only when COEF_GATHER_MAX_EN is defined; otherwise max_o is 0.
module coef_row_buf import gat_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_NODES  = DEF_MAX_NODES,
  parameter int ADDR_WIDTH = num_node_w(MAX_NODES) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            we_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  output logic [MAX_NODES*DATA_WIDTH-1:0] row_o,
  output logic [DATA_WIDTH-1:0]           max_o
);

  logic [MAX_NODES*DATA_WIDTH-1:0] row_q, row_d;

  always_comb begin
    row_d = row_q;
    if (clr_i) begin
      row_d = '0;
    end else if (we_i) begin
      for (int k = 0; k < MAX_NODES; k++) begin
        if (addr_i == ADDR_WIDTH'(k)) row_d[k*DATA_WIDTH +: DATA_WIDTH] = wdata_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) row_q <= '0;
    else     row_q <= row_d;
  end

  assign row_o = row_q;

`ifdef COEF_GATHER_MAX_EN
  logic [DATA_WIDTH-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (clr_i)                        max_d = '0;
    else if (we_i && wdata_i > max_q) max_d = wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) max_q <= '0;
    else     max_q <= max_d;
  end

  assign max_o = max_q;
`else
  assign max_o = '0;
`endif

endmodule

// File: rtl/coef_gather.sv
// Drains the coefficient FIFO into one row per subgraph node count and offers
// it to softmax. Row maximum output is enabled by COEF_GATHER_MAX_EN.
module coef_gather import gat_pkg::*; #(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int MAX_NODES      = DEF_MAX_NODES,
  parameter int NUM_NODE_WIDTH = num_node_w(MAX_NODES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
  input  logic                      coef_ff_empty,
  output logic                      coef_ff_rd_vld,
  input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
  input  logic                      num_node_ff_empty,
  output logic                      num_node_ff_rd_vld,
  coef_gather_if.master             sm,
  output logic                      ovf_o
);

  localparam int CW = NUM_NODE_WIDTH + 1;
  localparam logic [NUM_NODE_WIDTH-1:0] MAX_T = NUM_NODE_WIDTH'(MAX_NODES);

  coef_gather_state_t        state_q, state_d;
  logic [NUM_NODE_WIDTH-1:0] tgt_q, tgt_d;
  logic [CW-1:0]             issued_q, issued_d;
  logic [CW-1:0]             captured_q, captured_d;
  logic                      rd_dly_q;
  logic                      ovf_q, ovf_d;
  logic                      cap, last_cap, row_clr, nn_over;

  // Read data arrives one cycle after the strobe; the delayed strobe marks it.
  assign cap      = rd_dly_q && (state_q == GATHER);
  assign last_cap = cap && ((captured_q + CW'(1)) == {1'b0, tgt_q});
  assign nn_over  = num_node_ff_dout > MAX_T;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!num_node_ff_empty) state_d = GET_NUM;
      GET_NUM: state_d = (num_node_ff_dout == '0) ? OUT : GATHER;
      GATHER:  if (last_cap) state_d = OUT;
      OUT:     if (sm.sm_rdy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    num_node_ff_rd_vld = (state_q == IDLE) && !num_node_ff_empty;
    coef_ff_rd_vld     = (state_q == GATHER) && !coef_ff_empty && (issued_q < {1'b0, tgt_q});
    row_clr            = (state_q == GET_NUM) || ((state_q == OUT) && sm.sm_rdy_i);
  end

  always_comb begin
    tgt_d      = tgt_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    ovf_d      = ovf_q;
    if (state_q == GET_NUM) begin
      // Oversized counts are clamped; the surplus spills into the next row.
      tgt_d      = nn_over ? MAX_T : num_node_ff_dout;
      issued_d   = '0;
      captured_d = '0;
      ovf_d      = ovf_q | nn_over;
    end else begin
      if (coef_ff_rd_vld) issued_d   = issued_q + CW'(1);
      if (cap)            captured_d = captured_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_q      <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      rd_dly_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      tgt_q      <= tgt_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      rd_dly_q   <= coef_ff_rd_vld;
      ovf_q      <= ovf_d;
    end
  end

  coef_row_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_NODES  (MAX_NODES),
    .ADDR_WIDTH (CW)
  ) u_row_buf (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (row_clr),
    .we_i    (cap),
    .addr_i  (captured_q),
    .wdata_i (coef_ff_dout),
    .row_o   (sm.sm_coef_o),
    .max_o   (sm.sm_max_o)
  );

  assign sm.sm_vld_o      = (state_q == OUT);
  assign sm.sm_num_node_o = tgt_q;
  assign ovf_o            = ovf_q;

endmodule

// File: tb/tb_coef_gather.sv
// Directed bench for coef_gather: table of short rows plus hand-written
// back-pressure, full-row, overflow and mid-row reset sequences.
module tb_coef_gather;
  import gat_pkg::*;

  localparam int DW = 8;
  localparam int MN = 168;
  localparam int NW = 8;
  localparam int RW = MN * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] coef_ff_dout;
  logic          coef_ff_empty, coef_ff_rd_vld;
  logic [NW-1:0] num_node_ff_dout;
  logic          num_node_ff_empty, num_node_ff_rd_vld;
  logic          ovf_o;

  coef_gather_if #(.DATA_WIDTH(DW), .MAX_NODES(MN), .NUM_NODE_WIDTH(NW)) sm();

  coef_gather #(.DATA_WIDTH(DW), .MAX_NODES(MN), .NUM_NODE_WIDTH(NW)) dut (
    .clk                (clk),
    .rst                (rst),
    .coef_ff_dout       (coef_ff_dout),
    .coef_ff_empty      (coef_ff_empty),
    .coef_ff_rd_vld     (coef_ff_rd_vld),
    .num_node_ff_dout   (num_node_ff_dout),
    .num_node_ff_empty  (num_node_ff_empty),
    .num_node_ff_rd_vld (num_node_ff_rd_vld),
    .sm                 (sm),
    .ovf_o              (ovf_o)
  );

  always #5 clk = ~clk;

  // FIFO models with 1-cycle read latency
  logic [DW-1:0] cmem [0:1023];
  logic [NW-1:0] nmem [0:63];
  int c_wr = 0, c_rd = 0, n_wr = 0, n_rd = 0;
  int coef_reads = 0, nn_reads = 0, bad_reads = 0;
  bit bubble_en = 1'b0, bubble = 1'b0, flush = 1'b0;

  assign coef_ff_empty     = (c_wr == c_rd) || bubble;
  assign num_node_ff_empty = (n_wr == n_rd);

  always @(posedge clk) begin
    if (flush) begin
      c_rd <= c_wr;
      n_rd <= n_wr;
    end else begin
      if (coef_ff_rd_vld) begin
        coef_reads <= coef_reads + 1;
        if (coef_ff_empty) bad_reads <= bad_reads + 1;
        else begin
          coef_ff_dout <= cmem[c_rd];
          c_rd <= c_rd + 1;
        end
      end
      if (num_node_ff_rd_vld) begin
        nn_reads <= nn_reads + 1;
        if (num_node_ff_empty) bad_reads <= bad_reads + 1;
        else begin
          num_node_ff_dout <= nmem[n_rd];
          n_rd <= n_rd + 1;
        end
      end
    end
  end

  always @(negedge clk) bubble <= bubble_en ? ~bubble : 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] exp);
    logic [RW-1:0] act;
    act = sm.sm_coef_o;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int k = 0; k < MN; k++) begin
        if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $display("FAIL %s: slot %0d got %0d, expected %0d", name, k, act[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  task automatic push_c(input logic [DW-1:0] v);
    cmem[c_wr] = v;
    c_wr++;
  endtask

  task automatic push_n(input logic [NW-1:0] v);
    nmem[n_wr] = v;
    n_wr++;
  endtask

  task automatic wait_vld(output int cyc);
    cyc = 0;
    while (sm.sm_vld_o !== 1'b1 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 600) begin
      checks++;
      errors++;
      $display("FAIL wait_vld: got timeout after %0d cycles, expected sm_vld_o", cyc);
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  function automatic logic [31:0] em(input logic [DW-1:0] v);
`ifdef COEF_GATHER_MAX_EN
    return {24'd0, v};
`else
    return (v & 8'd0) | 32'd0;
`endif
  endfunction

  typedef struct {
    int             nn;
    logic [3:0][7:0] c;
    bit             bub;
    int             lat;
    logic [7:0]     mx;
  } vec_t;

  vec_t tbl [5];
  logic [RW-1:0] er;
  int cyc, r0, n0;

  initial begin
    tbl[0] = '{nn: 3, c: {8'd0,   8'd2, 8'd9,   8'd5},   bub: 1'b0, lat: 6,  mx: 8'd9};
    tbl[1] = '{nn: 0, c: {8'd0,   8'd0, 8'd0,   8'd0},   bub: 1'b0, lat: 2,  mx: 8'd0};
    tbl[2] = '{nn: 4, c: {8'd4,   8'd3, 8'd200, 8'd1},   bub: 1'b1, lat: -1, mx: 8'd200};
    tbl[3] = '{nn: 2, c: {8'd0,   8'd0, 8'd7,   8'd255}, bub: 1'b0, lat: 5,  mx: 8'd255};
    tbl[4] = '{nn: 1, c: {8'd0,   8'd0, 8'd0,   8'd128}, bub: 1'b0, lat: 4,  mx: 8'd128};

    rst = 1'b1;
    sm.sm_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld", {31'd0, sm.sm_vld_o}, 0);
    chk_row("rst_row", '0);
    chk("rst_num", {24'd0, sm.sm_num_node_o}, 0);
    chk("rst_max", {24'd0, sm.sm_max_o}, 0);
    chk("rst_ovf", {31'd0, ovf_o}, 0);
    chk("rst_coef_rd", {31'd0, coef_ff_rd_vld}, 0);
    chk("rst_nn_rd", {31'd0, num_node_ff_rd_vld}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      bubble_en = tbl[i].bub;
      r0 = coef_reads;
      n0 = nn_reads;
      for (int k = 0; k < tbl[i].nn; k++) push_c(tbl[i].c[k]);
      push_n(NW'(tbl[i].nn));
      wait_vld(cyc);
      if (tbl[i].lat >= 0) chk($sformatf("v%0d_lat", i), cyc, tbl[i].lat);
      er = '0;
      for (int k = 0; k < tbl[i].nn; k++) er[k*DW +: DW] = tbl[i].c[k];
      chk_row($sformatf("v%0d_row", i), er);
      chk($sformatf("v%0d_num", i), {24'd0, sm.sm_num_node_o}, tbl[i].nn);
      chk($sformatf("v%0d_max", i), {24'd0, sm.sm_max_o}, em(tbl[i].mx));
      @(negedge clk);
      chk($sformatf("v%0d_vld_drop", i), {31'd0, sm.sm_vld_o}, 0);
      chk_row($sformatf("v%0d_row_clr", i), '0);
      chk($sformatf("v%0d_coef_reads", i), coef_reads - r0, tbl[i].nn);
      chk($sformatf("v%0d_nn_reads", i), nn_reads - n0, 1);
      bubble_en = 1'b0;
    end

    // Back-pressure with the next row already queued
    sm.sm_rdy_i = 1'b0;
    bubble_en = 1'b1;
    r0 = coef_reads;
    n0 = nn_reads;
    push_c(8'd10); push_c(8'd20); push_c(8'd30); push_c(8'd40); push_c(8'd50);
    push_n(8'd3); push_n(8'd2);
    wait_vld(cyc);
    er = '0;
    er[0 +: DW] = 8'd10; er[DW +: DW] = 8'd20; er[2*DW +: DW] = 8'd30;
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("bp%0d_vld", s), {31'd0, sm.sm_vld_o}, 1);
      chk_row($sformatf("bp%0d_row", s), er);
      chk($sformatf("bp%0d_num", s), {24'd0, sm.sm_num_node_o}, 3);
      chk($sformatf("bp%0d_max", s), {24'd0, sm.sm_max_o}, em(8'd30));
      chk($sformatf("bp%0d_nn_rd", s), {31'd0, num_node_ff_rd_vld}, 0);
      chk($sformatf("bp%0d_coef_reads", s), coef_reads - r0, 3);
      chk($sformatf("bp%0d_nn_reads", s), nn_reads - n0, 1);
      @(negedge clk);
    end
    sm.sm_rdy_i = 1'b1;
    @(negedge clk);
    chk("bp_vld_drop", {31'd0, sm.sm_vld_o}, 0);
    wait_vld(cyc);
    er = '0;
    er[0 +: DW] = 8'd40; er[DW +: DW] = 8'd50;
    chk_row("bp_rowB", er);
    chk("bp_numB", {24'd0, sm.sm_num_node_o}, 2);
    chk("bp_maxB", {24'd0, sm.sm_max_o}, em(8'd50));
    @(negedge clk);
    chk("bp_coef_total", coef_reads - r0, 5);
    bubble_en = 1'b0;
    @(negedge clk);

    // Full row 0..167
    for (int k = 0; k < MN; k++) push_c(DW'(k));
    push_n(8'd168);
    wait_vld(cyc);
    er = '0;
    for (int k = 0; k < MN; k++) er[k*DW +: DW] = DW'(k);
    chk("full_lat", cyc, 171);
    chk_row("full_row", er);
    chk("full_num", {24'd0, sm.sm_num_node_o}, 168);
    chk("full_max", {24'd0, sm.sm_max_o}, em(8'd167));
    chk("full_ovf", {31'd0, ovf_o}, 0);
    @(negedge clk);

    // Overflow: 200 requested, 168 taken, surplus spills into next row
    for (int k = 0; k < 200; k++) push_c(DW'(k));
    push_n(8'd200);
    wait_vld(cyc);
    chk_row("ovf_row", er);
    chk("ovf_num", {24'd0, sm.sm_num_node_o}, 168);
    chk("ovf_flag", {31'd0, ovf_o}, 1);
    @(negedge clk);
    push_n(8'd2);
    wait_vld(cyc);
    er = '0;
    er[0 +: DW] = 8'd168; er[DW +: DW] = 8'd169;
    chk_row("spill_row", er);
    chk("spill_num", {24'd0, sm.sm_num_node_o}, 2);
    chk("spill_max", {24'd0, sm.sm_max_o}, em(8'd169));
    chk("ovf_sticky", {31'd0, ovf_o}, 1);
    @(negedge clk);

    // Reset after 2 of 4 captures
    do_flush();
    push_c(8'd10); push_c(8'd11); push_c(8'd12); push_c(8'd13);
    push_n(8'd4);
    repeat (5) @(negedge clk);
    chk("mid_num", {24'd0, sm.sm_num_node_o}, 4);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_vld", {31'd0, sm.sm_vld_o}, 0);
    chk_row("mrst_row", '0);
    chk("mrst_num", {24'd0, sm.sm_num_node_o}, 0);
    chk("mrst_max", {24'd0, sm.sm_max_o}, 0);
    chk("mrst_ovf", {31'd0, ovf_o}, 0);
    chk("mrst_coef_rd", {31'd0, coef_ff_rd_vld}, 0);
    chk("mrst_nn_rd", {31'd0, num_node_ff_rd_vld}, 0);
    rst = 1'b0;
    do_flush();
    push_c(8'd7);
    push_n(8'd1);
    wait_vld(cyc);
    chk("post_lat", cyc, 4);
    er = '0;
    er[0 +: DW] = 8'd7;
    chk_row("post_row", er);
    chk("post_num", {24'd0, sm.sm_num_node_o}, 1);
    chk("post_max", {24'd0, sm.sm_max_o}, em(8'd7));
    @(negedge clk);
    chk("post_vld_drop", {31'd0, sm.sm_vld_o}, 0);

    chk("bad_reads", bad_reads, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
